// File: rtl/sum_accumulator.sv
// Accumulates a fixed number of adder samples into a frame total and holds it
// on a valid/ready output until the consumer takes it.
module sum_accumulator #(
   parameter int SUM_W = 5,
   parameter int COUNT = 4,
   parameter int ACC_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [SUM_W-1:0] in_sum,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_overflow,
   output logic [3:0]       sample_cnt
);

   localparam logic [0:0] ACCUM = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;

   logic [0:0]       r_state;
   logic [ACC_W-1:0] r_acc;
   logic [3:0]       r_cnt;
   logic             r_overflow;
   logic             r_valid;

   logic [ACC_W:0]   w_sum;
   logic             w_accept;
   logic             w_last;

   // One extra bit on the adder exposes the wrap of the modulo accumulator.
   assign w_sum    = {1'b0, r_acc} + (ACC_W+1)'(in_sum);
   assign in_ready = !rst && (r_state == ACCUM) && !clear;
   assign w_accept = in_valid && in_ready;
   assign w_last   = (r_cnt == 4'(COUNT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ACCUM;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_overflow <= 1'b0;
         r_valid    <= 1'b0;
      end else if (clear) begin
         r_state    <= ACCUM;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_overflow <= 1'b0;
         r_valid    <= 1'b0;
      end else if (r_state == ACCUM) begin
         if (w_accept) begin
            r_acc <= w_sum[ACC_W-1:0];
            if (w_sum[ACC_W]) begin
               r_overflow <= 1'b1;
            end
            if (w_last) begin
               r_cnt   <= '0;
               r_state <= HOLD;
               r_valid <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 4'd1;
            end
         end
      end else if (out_ready) begin
         // Handoff cycle: the frame is consumed and no sample is taken.
         r_state    <= ACCUM;
         r_acc      <= '0;
         r_overflow <= 1'b0;
         r_valid    <= 1'b0;
      end
   end

   assign out_acc      = r_acc;
   assign out_valid    = r_valid;
   assign out_overflow = r_overflow;
   assign sample_cnt   = r_cnt;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: a frame-total model checked every cycle against two
// instances (7-bit and 6-bit accumulators) sharing one stimulus stream.
module tb_sum_accumulator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic [4:0] in_sum = '0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;

   logic       inReady7, outValid7, outOvf7;
   logic [6:0] outAcc7;
   logic [3:0] sampleCnt7;
   logic       inReady6, outValid6, outOvf6;
   logic [5:0] outAcc6;
   logic [3:0] sampleCnt6;

   int vectors = 0;
   int miscompares = 0;

   int mTotal = 0;
   int mCnt = 0;
   bit mHold = 1'b0;

   sum_accumulator #(.SUM_W(5), .COUNT(4), .ACC_W(7)) dut7 (
      .clk(clk), .rst(rst), .clear(clear), .in_sum(in_sum),
      .in_valid(in_valid), .in_ready(inReady7), .out_acc(outAcc7),
      .out_valid(outValid7), .out_ready(out_ready),
      .out_overflow(outOvf7), .sample_cnt(sampleCnt7)
   );

   sum_accumulator #(.SUM_W(5), .COUNT(4), .ACC_W(6)) dut6 (
      .clk(clk), .rst(rst), .clear(clear), .in_sum(in_sum),
      .in_valid(in_valid), .in_ready(inReady6), .out_acc(outAcc6),
      .out_valid(outValid6), .out_ready(out_ready),
      .out_overflow(outOvf6), .sample_cnt(sampleCnt6)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit v, input int s, input bit c, input bit r);
      @(negedge clk);
      in_valid  = v;
      in_sum    = 5'(s);
      clear     = c;
      out_ready = r;
   endtask

   task automatic afterEdge();
      @(posedge clk);
      #2;
   endtask

   // Model keeps the true (unwrapped) frame total; each instance's view is
   // that total modulo its width, and it has wrapped once the total reaches 2^W.
   always @(posedge rst) begin
      mTotal = 0;
      mCnt   = 0;
      mHold  = 1'b0;
   end

   always @(posedge clk) begin
      if (rst) begin
         mTotal = 0;
         mCnt   = 0;
         mHold  = 1'b0;
      end else if (clear) begin
         mTotal = 0;
         mCnt   = 0;
         mHold  = 1'b0;
      end else if (!mHold) begin
         if (in_valid) begin
            mTotal += int'(in_sum);
            mCnt++;
            if (mCnt == 4) begin
               mCnt  = 0;
               mHold = 1'b1;
            end
         end
      end else if (out_ready) begin
         mTotal = 0;
         mHold  = 1'b0;
      end
      #1;
      checkOutput("acc7", int'(outAcc7), mTotal % 128);
      checkOutput("ovf7", int'(outOvf7), int'(mTotal >= 128));
      checkOutput("valid7", int'(outValid7), int'(mHold));
      checkOutput("cnt7", int'(sampleCnt7), mCnt);
      checkOutput("ready7", int'(inReady7), int'(!rst && !mHold && !clear));
      checkOutput("acc6", int'(outAcc6), mTotal % 64);
      checkOutput("ovf6", int'(outOvf6), int'(mTotal >= 64));
      checkOutput("valid6", int'(outValid6), int'(mHold));
      checkOutput("ready6", int'(inReady6), int'(!rst && !mHold && !clear));
   end

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset mid-frame
      applyStimulus(1, 10, 0, 0);
      applyStimulus(1, 20, 0, 0);
      applyStimulus(0, 0, 0, 0);
      #2;
      checkOutput("lit preReset acc", int'(outAcc7), 30);
      rst = 1'b1;
      #1;
      checkOutput("lit reset acc", int'(outAcc7), 0);
      checkOutput("lit reset cnt", int'(sampleCnt7), 0);
      checkOutput("lit reset valid", int'(outValid7), 0);
      checkOutput("lit reset ovf", int'(outOvf7), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("lit release ready", int'(inReady7), 1);

      // Back-to-back frame
      applyStimulus(1, 3, 0, 1);
      applyStimulus(1, 7, 0, 1);
      applyStimulus(1, 15, 0, 1);
      applyStimulus(1, 30, 0, 1);
      afterEdge();
      checkOutput("lit b2b valid", int'(outValid7), 1);
      checkOutput("lit b2b acc", int'(outAcc7), 55);
      checkOutput("lit b2b ovf", int'(outOvf7), 0);
      checkOutput("lit b2b ready", int'(inReady7), 0);
      applyStimulus(0, 0, 0, 1);
      afterEdge();
      checkOutput("lit b2b handoff valid", int'(outValid7), 0);
      checkOutput("lit b2b handoff acc", int'(outAcc7), 0);

      // Backpressure with in_valid pulsed during HOLD
      applyStimulus(1, 3, 0, 0);
      applyStimulus(1, 7, 0, 0);
      applyStimulus(1, 15, 0, 0);
      applyStimulus(1, 30, 0, 0);
      afterEdge();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 9, 0, 0);
         afterEdge();
         checkOutput("lit hold acc", int'(outAcc7), 55);
         checkOutput("lit hold valid", int'(outValid7), 1);
      end
      applyStimulus(0, 0, 0, 1);
      afterEdge();
      checkOutput("lit hold release valid", int'(outValid7), 0);

      // Gapped input
      begin
         bit pattern [7] = '{1, 0, 1, 0, 0, 1, 1};
         for (int i = 0; i < 7; i++) begin
            applyStimulus(pattern[i], 5, 0, 0);
         end
      end
      afterEdge();
      checkOutput("lit gapped acc", int'(outAcc7), 20);
      checkOutput("lit gapped valid", int'(outValid7), 1);
      applyStimulus(0, 0, 0, 1);
      afterEdge();

      // Clear mid-frame, then a fresh frame
      applyStimulus(1, 10, 0, 0);
      applyStimulus(1, 20, 0, 0);
      applyStimulus(1, 5, 1, 0);
      #1;
      checkOutput("lit clear ready", int'(inReady7), 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1, 0, 0);
      end
      afterEdge();
      checkOutput("lit clear acc", int'(outAcc7), 4);
      checkOutput("lit clear valid", int'(outValid7), 1);

      // Clear while holding discards the pending frame
      applyStimulus(0, 0, 1, 0);
      afterEdge();
      checkOutput("lit clearHold valid", int'(outValid7), 0);
      checkOutput("lit clearHold acc", int'(outAcc7), 0);

      // Overflow on the 6-bit instance
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 30, 0, 0);
      end
      afterEdge();
      checkOutput("lit ovf6 acc", int'(outAcc6), 56);
      checkOutput("lit ovf6 flag", int'(outOvf6), 1);
      checkOutput("lit ovf7 acc", int'(outAcc7), 120);
      checkOutput("lit ovf7 flag", int'(outOvf7), 0);
      applyStimulus(0, 0, 0, 1);
      afterEdge();
      checkOutput("lit ovf6 handoff", int'(outOvf6), 0);

      applyStimulus(0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
